// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage. Holds the fetch address, applies
// prioritised redirect/stall/sequential updates, traps on misaligned redirect
// targets and stops fetch when the halt address is reached.
module pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h100),
  parameter logic [XLEN-1:0] HALT_ADDR  = XLEN'(248),
  parameter bit              HALT_EN    = 1'b1,
  parameter int unsigned     INST_BYTES = 4,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             valid_o,
  output logic             halted_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  bad_addr_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {StBoot, StRun, StTrap, StHalt} state_e;

  localparam logic [XLEN-1:0] AlignMask = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] Stride    = XLEN'(INST_BYTES);

  state_e            r_state, w_state_d;
  logic [XLEN-1:0]   r_pc, w_pc_d;
  logic [XLEN-1:0]   r_bad, w_bad_d;
  logic              r_mis, w_mis_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;

  logic              w_aligned;
  logic              w_load;
  logic [XLEN-1:0]   w_load_pc;
  logic              w_halt_hit;

  // Alignment of the redirect target and the candidate RUN-state pc load
  always_comb begin
    w_aligned  = ((redirect_pc_i & AlignMask) == '0);
    w_load     = 1'b0;
    w_load_pc  = r_pc;
    if (redirect_i) begin
      w_load    = 1'b1;
      w_load_pc = redirect_pc_i;
    end else if (!stall_i) begin
      w_load    = 1'b1;
      w_load_pc = r_pc + Stride;
    end
    w_halt_hit = HALT_EN && (w_load_pc == HALT_ADDR);
  end

  // State register
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_bad_d   = r_bad;
    w_mis_d   = r_mis;
    w_cnt_d   = r_cnt;
    case (r_state)
      StBoot: w_state_d = StRun;
      StRun: begin
        if (redirect_i && !w_aligned) begin
          w_pc_d    = TRAP_VEC;
          w_bad_d   = redirect_pc_i;
          w_mis_d   = 1'b1;
          w_cnt_d   = r_cnt + CNT_W'(1);
          w_state_d = StTrap;
        end else if (w_load) begin
          w_pc_d  = w_load_pc;
          w_cnt_d = r_cnt + CNT_W'(1);
          if (w_halt_hit) begin
            w_state_d = StHalt;
          end
        end
      end
      // The TRAP_VEC fetch is a bubble; resume with the instruction after it.
      StTrap: begin
        w_pc_d    = TRAP_VEC + Stride;
        w_state_d = StRun;
      end
      StHalt: w_state_d = StHalt;
      default: w_state_d = StBoot;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_pc  <= RESET_VEC;
      r_bad <= '0;
      r_mis <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_pc  <= w_pc_d;
      r_bad <= w_bad_d;
      r_mis <= w_mis_d;
      r_cnt <= w_cnt_d;
    end
  end

  // Output decode, driven only from registers
  always_comb begin
    pc_o        = r_pc;
    valid_o     = (r_state == StRun);
    halted_o    = (r_state == StHalt);
    misalign_o  = r_mis;
    bad_addr_o  = r_bad;
    fetch_cnt_o = r_cnt;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: default instance, halt-disabled instance and
// a narrow 8-bit instance with a 2-bit counter.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Instance A: defaults
  logic        start_a, stall_a, redir_a;
  logic [31:0] rpc_a, pc_a, bad_a;
  logic        valid_a, halted_a, mis_a;
  logic [15:0] cnt_a;

  // Instance B: halt detection disabled
  logic        start_b, stall_b, redir_b;
  logic [31:0] rpc_b, pc_b, bad_b;
  logic        valid_b, halted_b, mis_b;
  logic [15:0] cnt_b;

  // Instance C: 8-bit PC, 2-bit counter, no halt
  logic        start_c, stall_c, redir_c;
  logic [7:0]  rpc_c, pc_c, bad_c;
  logic        valid_c, halted_c, mis_c;
  logic [1:0]  cnt_c;

  pc_unit u_dut_a (
    .clk_i(clk), .start_i(start_a), .stall_i(stall_a), .redirect_i(redir_a),
    .redirect_pc_i(rpc_a), .pc_o(pc_a), .valid_o(valid_a), .halted_o(halted_a),
    .misalign_o(mis_a), .bad_addr_o(bad_a), .fetch_cnt_o(cnt_a)
  );

  pc_unit #(.HALT_EN(1'b0)) u_dut_b (
    .clk_i(clk), .start_i(start_b), .stall_i(stall_b), .redirect_i(redir_b),
    .redirect_pc_i(rpc_b), .pc_o(pc_b), .valid_o(valid_b), .halted_o(halted_b),
    .misalign_o(mis_b), .bad_addr_o(bad_b), .fetch_cnt_o(cnt_b)
  );

  pc_unit #(
    .XLEN(8), .TRAP_VEC(8'h80), .HALT_ADDR(8'hF8), .HALT_EN(1'b0),
    .INST_BYTES(4), .CNT_W(2)
  ) u_dut_c (
    .clk_i(clk), .start_i(start_c), .stall_i(stall_c), .redirect_i(redir_c),
    .redirect_pc_i(rpc_c), .pc_o(pc_c), .valid_o(valid_c), .halted_o(halted_c),
    .misalign_o(mis_c), .bad_addr_o(bad_c), .fetch_cnt_o(cnt_c)
  );

  task automatic test_reset();
    @(negedge clk);
    n_total++; if (pc_a !== 32'h0) $display("FAIL rst_pc: got %h want %h", pc_a, 32'h0); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_a); else n_pass++;
    n_total++; if (halted_a !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted_a); else n_pass++;
    n_total++; if (mis_a !== 1'b0) $display("FAIL rst_mis: got %b want 0", mis_a); else n_pass++;
    n_total++; if (bad_a !== 32'h0) $display("FAIL rst_bad: got %h want 0", bad_a); else n_pass++;
    n_total++; if (cnt_a !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", cnt_a); else n_pass++;
    start_a = 1'b1;
    #1;
    n_total++; if (valid_a !== 1'b0) $display("FAIL boot_valid: got %b want 0", valid_a); else n_pass++;
    @(negedge clk);
    n_total++; if (valid_a !== 1'b1) $display("FAIL run_valid: got %b want 1", valid_a); else n_pass++;
    n_total++; if (pc_a !== 32'h0) $display("FAIL run_pc0: got %h want 0", pc_a); else n_pass++;
    n_total++; if (cnt_a !== 16'd0) $display("FAIL run_cnt0: got %0d want 0", cnt_a); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_total++; if (pc_a !== 32'(4 * k)) $display("FAIL seq_pc: got %h want %h", pc_a, 32'(4 * k)); else n_pass++;
      n_total++; if (cnt_a !== 16'(k)) $display("FAIL seq_cnt: got %0d want %0d", cnt_a, k); else n_pass++;
    end
  endtask

  task automatic test_stall();
    stall_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++; if (pc_a !== 32'h10) $display("FAIL stall_pc: got %h want %h", pc_a, 32'h10); else n_pass++;
      n_total++; if (cnt_a !== 16'd4) $display("FAIL stall_cnt: got %0d want 4", cnt_a); else n_pass++;
    end
    redir_a = 1'b1;
    rpc_a   = 32'h40;
    @(negedge clk);
    n_total++; if (pc_a !== 32'h40) $display("FAIL flush_pc: got %h want %h", pc_a, 32'h40); else n_pass++;
    n_total++; if (cnt_a !== 16'd5) $display("FAIL flush_cnt: got %0d want 5", cnt_a); else n_pass++;
    stall_a = 1'b0;
    redir_a = 1'b0;
  endtask

  task automatic test_misalign();
    redir_a = 1'b1;
    rpc_a   = 32'h42;
    @(negedge clk);
    redir_a = 1'b0;
    n_total++; if (pc_a !== 32'h100) $display("FAIL trap_pc: got %h want %h", pc_a, 32'h100); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL trap_valid: got %b want 0", valid_a); else n_pass++;
    n_total++; if (mis_a !== 1'b1) $display("FAIL trap_mis: got %b want 1", mis_a); else n_pass++;
    n_total++; if (bad_a !== 32'h42) $display("FAIL trap_bad: got %h want %h", bad_a, 32'h42); else n_pass++;
    n_total++; if (cnt_a !== 16'd6) $display("FAIL trap_cnt: got %0d want 6", cnt_a); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_a !== 32'h104) $display("FAIL trap_exit_pc: got %h want %h", pc_a, 32'h104); else n_pass++;
    n_total++; if (valid_a !== 1'b1) $display("FAIL trap_exit_valid: got %b want 1", valid_a); else n_pass++;
    n_total++; if (cnt_a !== 16'd6) $display("FAIL trap_exit_cnt: got %0d want 6", cnt_a); else n_pass++;
  endtask

  task automatic test_back_to_back();
    // A second misaligned redirect overwrites the captured address
    redir_a = 1'b1;
    rpc_a   = 32'h1;
    @(negedge clk);
    redir_a = 1'b0;
    n_total++; if (bad_a !== 32'h1) $display("FAIL bad_overwrite: got %h want %h", bad_a, 32'h1); else n_pass++;
    n_total++; if (pc_a !== 32'h100) $display("FAIL trap2_pc: got %h want %h", pc_a, 32'h100); else n_pass++;
    n_total++; if (cnt_a !== 16'd7) $display("FAIL trap2_cnt: got %0d want 7", cnt_a); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_a !== 32'h104) $display("FAIL trap2_exit_pc: got %h want %h", pc_a, 32'h104); else n_pass++;
    n_total++; if (mis_a !== 1'b1) $display("FAIL mis_sticky: got %b want 1", mis_a); else n_pass++;
  endtask

  task automatic test_halt();
    redir_a = 1'b1;
    rpc_a   = 32'hF0;
    @(negedge clk);
    redir_a = 1'b0;
    n_total++; if (pc_a !== 32'hF0) $display("FAIL pre_halt_pc: got %h want %h", pc_a, 32'hF0); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_a !== 32'hF4) $display("FAIL pre_halt_pc2: got %h want %h", pc_a, 32'hF4); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_a !== 32'hF8) $display("FAIL halt_pc: got %h want %h", pc_a, 32'hF8); else n_pass++;
    n_total++; if (halted_a !== 1'b1) $display("FAIL halt_flag: got %b want 1", halted_a); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL halt_valid: got %b want 0", valid_a); else n_pass++;
    n_total++; if (cnt_a !== 16'd10) $display("FAIL halt_cnt: got %0d want 10", cnt_a); else n_pass++;
    redir_a = 1'b1;
    rpc_a   = 32'h20;
    stall_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_total++; if (pc_a !== 32'hF8) $display("FAIL halt_hold_pc: got %h want %h", pc_a, 32'hF8); else n_pass++;
      n_total++; if (cnt_a !== 16'd10) $display("FAIL halt_hold_cnt: got %0d want 10", cnt_a); else n_pass++;
    end
    redir_a = 1'b0;
    stall_a = 1'b0;
  endtask

  task automatic test_async_reset();
    // Reset mid-cycle while halted
    #2 start_a = 1'b0;
    #1;
    n_total++; if (pc_a !== 32'h0) $display("FAIL areset_halt_pc: got %h want 0", pc_a); else n_pass++;
    n_total++; if (halted_a !== 1'b0) $display("FAIL areset_halt_flag: got %b want 0", halted_a); else n_pass++;
    n_total++; if (mis_a !== 1'b0) $display("FAIL areset_halt_mis: got %b want 0", mis_a); else n_pass++;
    n_total++; if (cnt_a !== 16'd0) $display("FAIL areset_halt_cnt: got %0d want 0", cnt_a); else n_pass++;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    redir_a = 1'b1;
    rpc_a   = 32'h6;
    @(negedge clk);
    redir_a = 1'b0;
    n_total++; if (pc_a !== 32'h100) $display("FAIL pre_areset_trap_pc: got %h want %h", pc_a, 32'h100); else n_pass++;
    // Reset mid-cycle while trapping
    #2 start_a = 1'b0;
    #1;
    n_total++; if (pc_a !== 32'h0) $display("FAIL areset_trap_pc: got %h want 0", pc_a); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL areset_trap_valid: got %b want 0", valid_a); else n_pass++;
    n_total++; if (mis_a !== 1'b0) $display("FAIL areset_trap_mis: got %b want 0", mis_a); else n_pass++;
    n_total++; if (bad_a !== 32'h0) $display("FAIL areset_trap_bad: got %h want 0", bad_a); else n_pass++;
    n_total++; if (cnt_a !== 16'd0) $display("FAIL areset_trap_cnt: got %0d want 0", cnt_a); else n_pass++;
  endtask

  task automatic test_no_halt();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    redir_b = 1'b1;
    rpc_b   = 32'hF4;
    @(negedge clk);
    redir_b = 1'b0;
    n_total++; if (pc_b !== 32'hF4) $display("FAIL nohalt_pc0: got %h want %h", pc_b, 32'hF4); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_b !== 32'hF8) $display("FAIL nohalt_pc1: got %h want %h", pc_b, 32'hF8); else n_pass++;
    n_total++; if (halted_b !== 1'b0) $display("FAIL nohalt_flag: got %b want 0", halted_b); else n_pass++;
    n_total++; if (valid_b !== 1'b1) $display("FAIL nohalt_valid: got %b want 1", valid_b); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_b !== 32'hFC) $display("FAIL nohalt_pc2: got %h want %h", pc_b, 32'hFC); else n_pass++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    n_total++; if (cnt_c !== 2'd0) $display("FAIL wrap_cnt0: got %0d want 0", cnt_c); else n_pass++;
    redir_c = 1'b1;
    rpc_c   = 8'hFC;
    @(negedge clk);
    redir_c = 1'b0;
    n_total++; if (pc_c !== 8'hFC) $display("FAIL wrap_pc0: got %h want %h", pc_c, 8'hFC); else n_pass++;
    n_total++; if (cnt_c !== 2'd1) $display("FAIL wrap_cnt1: got %0d want 1", cnt_c); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_c !== 8'h00) $display("FAIL wrap_pc1: got %h want 0", pc_c); else n_pass++;
    n_total++; if (valid_c !== 1'b1) $display("FAIL wrap_valid: got %b want 1", valid_c); else n_pass++;
    @(negedge clk);
    n_total++; if (cnt_c !== 2'd3) $display("FAIL wrap_cnt3: got %0d want 3", cnt_c); else n_pass++;
    @(negedge clk);
    n_total++; if (pc_c !== 8'h08) $display("FAIL wrap_pc3: got %h want %h", pc_c, 8'h08); else n_pass++;
    n_total++; if (cnt_c !== 2'd0) $display("FAIL cnt_wrap: got %0d want 0", cnt_c); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    start_a = 1'b1; stall_a = 1'b0; redir_a = 1'b0; rpc_a = '0;
    start_b = 1'b1; stall_b = 1'b0; redir_b = 1'b0; rpc_b = '0;
    start_c = 1'b1; stall_c = 1'b0; redir_c = 1'b0; rpc_c = '0;
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    test_reset();
    test_stall();
    test_misalign();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_no_halt();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
